// File: rtl/semaforo_pkg.sv
// -----------------------------------------------------------------------------
// semaforo_pkg
// Shared definitions for the intersection phase scheduler.
//   - lamp colour encodings, one 3-bit slice per approach {green, yellow, red}
//   - scheduler state enum
// No ports; imported by semaforo_sched.
// -----------------------------------------------------------------------------
package semaforo_pkg;

    localparam logic [2:0] COR_VERDE    = 3'b100;
    localparam logic [2:0] COR_AMARELO  = 3'b010;
    localparam logic [2:0] COR_VERMELHO = 3'b001;

    typedef enum logic [1:0] {
        ST_GREEN,
        ST_YELLOW,
        ST_ALLRED
    } st_e;

endpackage

// File: rtl/semaforo_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick among pending calls. The search starts at
// the approach after i_phase and wraps; i_phase itself is the last candidate.
// When nothing is pending both outputs are zero.
// Ports:
//   i_pend     in  N    pending call bits
//   i_phase    in  PW   approach currently owning the right of way
//   o_gnt_oh   out N    one-hot winner (all zero if i_pend == 0)
//   o_gnt_bin  out PW   binary winner  (zero if i_pend == 0)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_pend,
    input  logic [PW-1:0] i_phase,
    output logic [N-1:0]  o_gnt_oh,
    output logic [PW-1:0] o_gnt_bin
);

    int w_idx;

    // Walk from the farthest candidate to the nearest so the nearest pending
    // approach (in round-robin order) is the last, winning assignment.
    always_comb begin
        o_gnt_oh  = '0;
        o_gnt_bin = '0;
        w_idx     = 0;
        for (int k = N; k >= 1; k--) begin
            w_idx = (int'(i_phase) + k) % N;
            if (i_pend[w_idx]) begin
                o_gnt_oh        = '0;
                o_gnt_oh[w_idx] = 1'b1;
                o_gnt_bin       = PW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/semaforo_sched.sv
// -----------------------------------------------------------------------------
// semaforo_sched
// Round-robin phase scheduler for an N_APP-approach intersection. Calls are
// latched per approach; green is granted to one approach at a time and every
// handover runs green -> yellow -> all-red. Approach 0 (main road) rests in
// green while nothing else is pending.
//
// Optional feature macro: SEMAFORO_EXTEND_EN
//   When defined, green is held past T_GREEN while req[phase]=1, up to
//   T_MAXGREEN ticks. When undefined, T_MAXGREEN has no effect.
//
// Ports:
//   clk     in   1        rising-edge clock
//   rst     in   1        asynchronous active-low reset
//   tick    in   1        time-base enable; timers advance only on tick
//   req     in   N_APP    call request per approach (level, sampled every clk)
//   lights  out  3*N_APP  slice [3i+2:3i]: 100 green, 010 yellow, 001 red
//   phase   out  PW       approach owning green/yellow
//   served  out  N_APP    1-clk pulse when approach i enters green
//   busy    out  1        0 only when resting: green, phase 0, nothing pending
// -----------------------------------------------------------------------------
module semaforo_sched
    import semaforo_pkg::*;
#(
    parameter int N_APP      = 4,
    parameter int T_GREEN    = 8,
    parameter int T_YELLOW   = 3,
    parameter int T_ALLRED   = 1,
    parameter int T_MAXGREEN = 16,
    parameter int CW         = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic [N_APP-1:0]         req,
    output logic [3*N_APP-1:0]       lights,
    output logic [$clog2(N_APP)-1:0] phase,
    output logic [N_APP-1:0]         served,
    output logic                     busy
);

    localparam int PW = $clog2(N_APP);

`ifdef SEMAFORO_EXTEND_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif

    // Timer terminal values. Green saturates higher when extension is built in
    // so the hold can run on to the ceiling.
    localparam logic [CW-1:0] LIM_GREEN  = CW'(T_GREEN - 1);
    localparam logic [CW-1:0] LIM_GSAT   = EXT_EN ? CW'(T_MAXGREEN - 1) : CW'(T_GREEN - 1);
    localparam logic [CW-1:0] LIM_YELLOW = CW'(T_YELLOW - 1);
    localparam logic [CW-1:0] LIM_ALLRED = CW'(T_ALLRED - 1);

    st_e                r_state;
    logic [CW-1:0]      r_cnt;
    logic [PW-1:0]      r_phase;
    logic [PW-1:0]      r_nxt;
    logic [N_APP-1:0]   r_nxt_oh;
    logic [N_APP-1:0]   r_pend;
    logic [N_APP-1:0]   r_served;
    logic [3*N_APP-1:0] r_lights;

    logic [N_APP-1:0]   w_win_oh;
    logic [PW-1:0]      w_win_bin;
    logic [N_APP-1:0]   w_pend_set;
    logic [N_APP-1:0]   w_pend_clr;
    logic [CW-1:0]      w_lim;
    logic               w_exit;
    logic               w_hold;

    rr_arbiter #(
        .N  (N_APP),
        .PW (PW)
    ) u_arb (
        .i_pend    (r_pend),
        .i_phase   (r_phase),
        .o_gnt_oh  (w_win_oh),
        .o_gnt_bin (w_win_bin)
    );

    function automatic logic [3*N_APP-1:0] f_lights(input st_e st, input logic [PW-1:0] ph);
        logic [3*N_APP-1:0] l;
        for (int i = 0; i < N_APP; i++) begin
            l[3*i +: 3] = COR_VERMELHO;
            if (i == int'(ph)) begin
                if (st == ST_GREEN)
                    l[3*i +: 3] = COR_VERDE;
                else if (st == ST_YELLOW)
                    l[3*i +: 3] = COR_AMARELO;
            end
        end
        return l;
    endfunction

    always_comb begin
        // The owner's own request is ignored while it holds green/yellow; in
        // all-red the right of way is already gone, so it can call again.
        w_pend_set = '0;
        for (int i = 0; i < N_APP; i++) begin
            if (req[i] && ((i != int'(r_phase)) || (r_state == ST_ALLRED)))
                w_pend_set[i] = 1'b1;
        end

        w_hold = 1'b0;
`ifdef SEMAFORO_EXTEND_EN
        w_hold = req[r_phase] && (r_cnt != LIM_GSAT);
`endif

        w_lim  = LIM_GSAT;
        w_exit = 1'b0;
        case (r_state)
            ST_GREEN: begin
                w_lim  = LIM_GSAT;
                w_exit = (r_cnt >= LIM_GREEN) && ((|r_pend) || (r_phase != '0)) && !w_hold;
            end
            ST_YELLOW: begin
                w_lim  = LIM_YELLOW;
                w_exit = (r_cnt == LIM_YELLOW);
            end
            ST_ALLRED: begin
                w_lim  = LIM_ALLRED;
                w_exit = (r_cnt == LIM_ALLRED);
            end
            default: ;
        endcase

        // Clearing the incoming approach takes priority over a same-edge set.
        w_pend_clr = (tick && w_exit && (r_state == ST_ALLRED)) ? r_nxt_oh : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_GREEN;
            r_cnt    <= '0;
            r_phase  <= '0;
            r_nxt    <= '0;
            r_nxt_oh <= '0;
            r_pend   <= '0;
            r_served <= '0;
            r_lights <= f_lights(ST_GREEN, '0);
        end else begin
            r_served <= '0;
            r_pend   <= (r_pend | w_pend_set) & ~w_pend_clr;
            if (tick) begin
                if (w_exit) begin
                    r_cnt <= '0;
                    case (r_state)
                        ST_GREEN: begin
                            // Winner is frozen here; later calls wait a cycle.
                            r_state  <= ST_YELLOW;
                            r_nxt    <= w_win_bin;
                            r_nxt_oh <= (|r_pend) ? w_win_oh : N_APP'(1);
                            r_lights <= f_lights(ST_YELLOW, r_phase);
                        end
                        ST_YELLOW: begin
                            r_state  <= ST_ALLRED;
                            r_lights <= f_lights(ST_ALLRED, r_phase);
                        end
                        ST_ALLRED: begin
                            r_state  <= ST_GREEN;
                            r_phase  <= r_nxt;
                            r_served <= r_nxt_oh;
                            r_lights <= f_lights(ST_GREEN, r_nxt);
                        end
                        default: begin
                            r_state  <= ST_GREEN;
                            r_phase  <= '0;
                            r_lights <= f_lights(ST_GREEN, '0);
                        end
                    endcase
                end else if (r_cnt != w_lim) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign lights = r_lights;
    assign phase  = r_phase;
    assign served = r_served;
    assign busy   = !((r_state == ST_GREEN) && (r_phase == '0) && (r_pend == '0));

endmodule

// File: tb/tb_semaforo_sched.sv
// -----------------------------------------------------------------------------
// tb_semaforo_sched
// Scoreboard bench for semaforo_sched with default parameters (4 approaches).
// The driver applies one clock of stimulus per step, advances a behavioural
// model of the intersection and queues the expected outputs; a monitor forked
// alongside pops and compares them on every falling edge. Directed sections
// add explicit timing/order checks on top of the cycle-by-cycle comparison.
// -----------------------------------------------------------------------------
module tb_semaforo_sched;

    localparam int N     = 4;
    localparam int PW    = 2;
    localparam int T_G   = 8;
    localparam int T_Y   = 3;
    localparam int T_A   = 1;
    localparam int T_MAX = 16;
    localparam int W     = 3*N + PW + N + 1;

`ifdef SEMAFORO_EXTEND_EN
    localparam int EXP_HOLD = T_MAX;
    localparam bit EXT      = 1'b1;
`else
    localparam int EXP_HOLD = T_G;
    localparam bit EXT      = 1'b0;
`endif

    localparam logic [3*N-1:0] RST_LIGHTS = 12'b001_001_001_100;
    localparam logic [3*N-1:0] ALL_RED    = 12'b001_001_001_001;

    logic            clk  = 1'b0;
    logic            rst  = 1'b0;
    logic            tick = 1'b0;
    logic [N-1:0]    req  = '0;
    logic [3*N-1:0]  lights;
    logic [PW-1:0]   phase;
    logic [N-1:0]    served;
    logic            busy;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // Reference model: colour of the current owner (0 green, 1 yellow,
    // 2 all-red), owner, chosen successor, ticks spent in the current colour
    // and the set of waiting calls.
    int           m_col, m_ph, m_nxt, m_ticks;
    logic [N-1:0] m_calls, m_served;

    semaforo_sched #(
        .N_APP      (N),
        .T_GREEN    (T_G),
        .T_YELLOW   (T_Y),
        .T_ALLRED   (T_A),
        .T_MAXGREEN (T_MAX),
        .CW         (5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .req    (req),
        .lights (lights),
        .phase  (phase),
        .served (served),
        .busy   (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic int pick_next(input logic [N-1:0] calls, input int from);
        for (int k = 1; k <= N; k++) begin
            if (calls[(from + k) % N]) return (from + k) % N;
        end
        return 0;
    endfunction

    function automatic void model_reset();
        m_col = 0; m_ph = 0; m_nxt = 0; m_ticks = 0;
        m_calls = '0; m_served = '0;
    endfunction

    function automatic void model_step(input logic t, input logic [N-1:0] r);
        logic [N-1:0] nc;
        bit leave;
        if (!rst) begin
            model_reset();
            return;
        end
        nc = m_calls;
        for (int i = 0; i < N; i++)
            if (r[i] && (i != m_ph || m_col == 2)) nc[i] = 1'b1;
        m_served = '0;
        if (t) begin
            case (m_col)
                0: begin
                    leave = (m_ticks + 1 >= T_G) && (m_calls != 0 || m_ph != 0);
                    if (EXT && r[m_ph] && (m_ticks + 1 < T_MAX)) leave = 1'b0;
                end
                1:       leave = (m_ticks + 1 >= T_Y);
                default: leave = (m_ticks + 1 >= T_A);
            endcase
            if (!leave) begin
                m_ticks++;
            end else begin
                m_ticks = 0;
                if (m_col == 0) begin
                    m_nxt = pick_next(m_calls, m_ph);
                    m_col = 1;
                end else if (m_col == 1) begin
                    m_col = 2;
                end else begin
                    m_col = 0;
                    m_ph  = m_nxt;
                    m_served[m_ph] = 1'b1;
                    nc[m_ph] = 1'b0;
                end
            end
        end
        m_calls = nc;
    endfunction

    function automatic logic [W-1:0] pack_exp();
        logic [3*N-1:0] l;
        logic           b;
        for (int i = 0; i < N; i++) begin
            if (i == m_ph && m_col == 0)      l[3*i +: 3] = 3'b100;
            else if (i == m_ph && m_col == 1) l[3*i +: 3] = 3'b010;
            else                              l[3*i +: 3] = 3'b001;
        end
        b = !(m_col == 0 && m_ph == 0 && m_calls == 0);
        return {l, PW'(m_ph), m_served, b};
    endfunction

    function automatic int count_lit(input logic [3*N-1:0] l);
        int c = 0;
        for (int i = 0; i < N; i++) if (l[3*i +: 3] != 3'b001) c++;
        return c;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h (%0d), want 0x%0h (%0d)", name, $time, got, got, want, want);
        end
    endtask

    task automatic monitor_loop();
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs{lights,phase,served,busy}", 32'({lights, phase, served, busy}), 32'(e));
                check("one_lit", 32'(count_lit(lights) <= 1), 32'd1);
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic t, input logic [N-1:0] r);
        @(negedge clk);
        tick = t;
        req  = r;
        model_step(t, r);
        @(posedge clk);
        #1;
        exp_q.push_back(pack_exp());
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst  = 1'b0;
        tick = 1'b0;
        req  = '0;
        model_reset();
        #1;
        check("rst_lights", 32'(lights), 32'(RST_LIGHTS));
        check("rst_phase",  32'(phase),  32'd0);
        check("rst_served", 32'(served), 32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        @(posedge clk);
        #1;
        exp_q.push_back(pack_exp());
        repeat (2) step(1'b0, '0);
        @(negedge clk);
        rst  = 1'b1;
        model_step(1'b0, '0);
        @(posedge clk);
        #1;
        exp_q.push_back(pack_exp());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t_y0, t_ar, t_g2, t_y2, t_g0;
        int order[$];
        int zero_busy, g, n_g3, n_y3, n_served;
        bit found, seen1;

        fork
            monitor_loop();
        join_none

        // T1: reset and idle rest on approach 0
        do_reset();
        repeat (50) step(1'b1, '0);
        check("t1_idle_busy",   32'(busy),   32'd0);
        check("t1_idle_lights", 32'(lights), 32'(RST_LIGHTS));

        // T2: single call on approach 2 right after reset
        do_reset();
        t_y0 = -1; t_ar = -1; t_g2 = -1; t_y2 = -1; t_g0 = -1;
        for (int s = 1; s <= 30; s++) begin
            step(1'b1, (s == 1) ? 4'b0100 : 4'b0000);
            if (t_y0 < 0 && lights[2:0] == 3'b010) t_y0 = s;
            if (t_ar < 0 && t_y0 > 0 && lights == ALL_RED) t_ar = s;
            if (t_g2 < 0 && served[2]) t_g2 = s;
            if (t_y2 < 0 && lights[8:6] == 3'b010) t_y2 = s;
            if (t_g0 < 0 && t_g2 > 0 && lights[2:0] == 3'b100) t_g0 = s;
        end
        check("t2_yellow0", t_y0, 8);
        check("t2_allred",  t_ar, 11);
        check("t2_green2",  t_g2, 12);
        check("t2_yellow2", t_y2, 20);
        check("t2_green0",  t_g0, 24);

        // T3: three calls at once are served in round-robin order
        step(1'b1, 4'b1110);
        order.delete();
        for (int s = 0; s < 80; s++) begin
            step(1'b1, '0);
            for (int i = 0; i < N; i++) if (served[i]) order.push_back(i);
        end
        check("t3_served_count", order.size(), 4);
        check("t3_order", (order.size() >= 4) ? order[0]*1000 + order[1]*100 + order[2]*10 + order[3] : -1, 1230);

        // T4: call on 1 arrives during the yellow of the 0 -> 2 handover
        step(1'b1, 4'b0100);
        found = 0;
        for (int s = 0; s < 20 && !found; s++) begin
            step(1'b1, '0);
            if (lights[2:0] == 3'b010) found = 1;
        end
        check("t4_reach_yellow", 32'(found), 32'd1);
        step(1'b1, 4'b0010);
        order.delete();
        zero_busy = 0; seen1 = 0;
        for (int s = 0; s < 60; s++) begin
            step(1'b1, '0);
            for (int i = 0; i < N; i++) if (served[i]) order.push_back(i);
            if (served[1]) seen1 = 1;
            if (!seen1 && !busy) zero_busy++;
        end
        check("t4_order", (order.size() >= 3) ? order[0]*100 + order[1]*10 + order[2] : -1, 210);
        check("t4_pend_held", zero_busy, 0);

        // T5: tick every 4th clock, call latched while tick=0
        step(1'b0, 4'b1000);
        check("t5_latch_notick", 32'(busy), 32'd1);
        n_g3 = 0; n_y3 = 0;
        for (int c = 0; c < 240; c++) begin
            step((c % 4) == 3, '0);
            if (lights[11:9] == 3'b100) n_g3++;
            if (lights[11:9] == 3'b010) n_y3++;
        end
        check("t5_green3_clks",  n_g3, 4*T_G);
        check("t5_yellow3_clks", n_y3, 4*T_Y);

        // T6: app2 holds its own request with a call pending on 0
        step(1'b1, 4'b0100);
        found = 0;
        for (int s = 0; s < 40 && !found; s++) begin
            step(1'b1, '0);
            if (served[2]) found = 1;
        end
        check("t6_reach_green2", 32'(found), 32'd1);
        g = 1;
        for (int s = 0; s < 40; s++) begin
            step(1'b1, (s == 0) ? 4'b0101 : 4'b0100);
            if (lights[8:6] == 3'b100) g++;
            else break;
        end
        check("t6_green2_len", g, EXP_HOLD);
        check("t6_in_yellow", 32'(lights[8:6]), 32'(3'b010));
        // reset in the middle of yellow drops the pending call on 0
        do_reset();
        n_served = 0;
        for (int s = 0; s < 30; s++) begin
            step(1'b1, '0);
            if (served != '0) n_served++;
        end
        check("t6_pend_lost", n_served, 0);

        // Random traffic
        for (int s = 0; s < 600; s++) begin
            logic [N-1:0] r;
            for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 19) == 0);
            step($urandom_range(0, 3) != 0, r);
        end

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
